// File: rtl/perf_counters_if.sv
// perf_counters_if
//   Bundles the count-control and read-port signals of perf_counters.
//   The master side (core / bench) drives the event strobes, the control
//   levels and the read request. The slave side (perf_counters) returns
//   the registered read data and the status flags.
//
//   Signals
//     enable    global count enable
//     events    per-cycle event strobes, bit i feeds counter i+1
//     halt      processor halt retired, freezes counting
//     clear     synchronous clear of counters, overflow flags and freeze
//     rd_req    read request
//     rd_sel    counter index, 0 = cycles, 1..NUM_EVENTS = events
//     rd_valid  read data valid, one cycle after rd_req
//     rd_data   selected counter value
//     rd_err    rd_sel was out of range (qualified by rd_valid)
//     ovf       sticky saturation flags, bit k belongs to counter k
//     frozen    counting stopped by halt
interface perf_counters_if #(
    parameter int NUM_EVENTS = 6,
    parameter int CNT_WIDTH  = 32,
    parameter int SEL_W      = 4
) ();

    logic                  enable;
    logic [NUM_EVENTS-1:0] events;
    logic                  halt;
    logic                  clear;
    logic                  rd_req;
    logic [SEL_W-1:0]      rd_sel;
    logic                  rd_valid;
    logic [CNT_WIDTH-1:0]  rd_data;
    logic                  rd_err;
    logic [NUM_EVENTS:0]   ovf;
    logic                  frozen;

    modport master (
        output enable, events, halt, clear, rd_req, rd_sel,
        input  rd_valid, rd_data, rd_err, ovf, frozen
    );

    modport slave (
        input  enable, events, halt, clear, rd_req, rd_sel,
        output rd_valid, rd_data, rd_err, ovf, frozen
    );

endinterface

// File: rtl/perf_counters.sv
// perf_counters
//   On-chip performance counters: a free-running cycle counter (index 0)
//   plus NUM_EVENTS event counters (index 1..NUM_EVENTS). All counters are
//   unsigned and saturate at all-ones, setting a sticky overflow flag.
//   A retired halt freezes counting until clear. A single-cycle registered
//   read port returns any counter one cycle after the request.
//
//   Ports
//     clk   single clock, all state changes on posedge
//     rst   synchronous active-low reset
//     bus   perf_counters_if slave modport (controls, read port, status)
module perf_counters #(
    parameter int NUM_EVENTS = 6,
    parameter int CNT_WIDTH  = 32,
    parameter int SEL_W      = 4
) (
    input logic            clk,
    input logic            rst,
    perf_counters_if.slave bus
);

    localparam int NCNT = NUM_EVENTS + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] cnt_q [NCNT];
    logic [CNT_WIDTH-1:0] cnt_d [NCNT];
    logic [NCNT-1:0]      ovf_q;
    logic [NCNT-1:0]      ovf_d;
    logic [NCNT-1:0]      inc;
    logic                 frozen_q;
    logic                 frozen_d;
    logic                 active;

    logic                 rd_valid_q;
    logic                 rd_valid_d;
    logic                 rd_err_q;
    logic                 rd_err_d;
    logic [CNT_WIDTH-1:0] rd_data_q;
    logic [CNT_WIDTH-1:0] rd_data_d;

    // Counter 0 counts every active cycle; counter i follows events[i-1].
    always_comb begin
        inc    = {bus.events, 1'b1};
        active = bus.enable && !frozen_q && !bus.clear;
    end

    // Clear has priority over increment and saturation. At the ceiling a
    // further increment leaves the value alone and latches the overflow flag.
    always_comb begin
        for (int k = 0; k < NCNT; k++) begin
            cnt_d[k] = cnt_q[k];
            ovf_d[k] = ovf_q[k];
            if (bus.clear) begin
                cnt_d[k] = '0;
                ovf_d[k] = 1'b0;
            end else if (active && inc[k]) begin
                if (cnt_q[k] == CNT_MAX) begin
                    ovf_d[k] = 1'b1;
                end else begin
                    cnt_d[k] = cnt_q[k] + CNT_ONE;
                end
            end
        end
    end

    // The halt cycle itself still counts (active uses frozen_q), freeze takes
    // effect from the next cycle. Clear in the same cycle wins.
    always_comb begin
        frozen_d = frozen_q;
        if (bus.clear) begin
            frozen_d = 1'b0;
        end else if (bus.halt) begin
            frozen_d = 1'b1;
        end
    end

    // Read mux samples the registered counters, so a read returns the value
    // from before this cycle's increment or clear.
    always_comb begin
        rd_valid_d = bus.rd_req;
        rd_err_d   = 1'b0;
        rd_data_d  = '0;
        if (bus.rd_req) begin
            if (int'(bus.rd_sel) > NUM_EVENTS) begin
                rd_err_d = 1'b1;
            end else begin
                for (int k = 0; k < NCNT; k++) begin
                    if (int'(bus.rd_sel) == k) begin
                        rd_data_d = cnt_q[k];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < NCNT; k++) begin
                cnt_q[k] <= '0;
            end
            ovf_q      <= '0;
            frozen_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            for (int k = 0; k < NCNT; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
            ovf_q      <= ovf_d;
            frozen_q   <= frozen_d;
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_err   = rd_err_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.ovf      = ovf_q;
    assign bus.frozen   = frozen_q;

endmodule

// File: tb/tb_perf_counters.sv
// tb_perf_counters
//   Directed bench for perf_counters with an 8-bit counter width so that
//   saturation is reachable. Reads push their expected response into a
//   scoreboard queue; a monitor on the falling edge pops and compares
//   whenever rd_valid is presented. Status flags are checked directly.
module tb_perf_counters;

    localparam int NE = 6;
    localparam int CW = 8;
    localparam int SW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    perf_counters_if #(.NUM_EVENTS(NE), .CNT_WIDTH(CW), .SEL_W(SW)) pif ();

    perf_counters #(.NUM_EVENTS(NE), .CNT_WIDTH(CW), .SEL_W(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (pif)
    );

    typedef struct {
        logic [CW-1:0] data;
        logic          err;
        string         name;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input int sel, input int exp_d, input logic exp_e, input string name);
        exp_t e;
        e.data = exp_d[CW-1:0];
        e.err  = exp_e;
        e.name = name;
        sb_q.push_back(e);
        pif.rd_req = 1'b1;
        pif.rd_sel = sel[SW-1:0];
        cyc(1);
        pif.rd_req = 1'b0;
        pif.rd_sel = '0;
    endtask

    // Monitor: compare each presented read against the oldest expectation;
    // when idle, the read outputs must be quiet.
    always @(negedge clk) begin
        if (pif.rd_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_rd_valid: got rd_valid=1 data=%0d, expected no read", pif.rd_data);
            end else begin
                mon_e = sb_q.pop_front();
                check({mon_e.name, "_data"}, 32'(pif.rd_data), 32'(mon_e.data));
                check({mon_e.name, "_err"}, 32'(pif.rd_err), 32'(mon_e.err));
            end
        end else begin
            check("idle_rd_data", 32'(pif.rd_data), 32'd0);
            check("idle_rd_err", 32'(pif.rd_err), 32'd0);
        end
    end

    initial begin
        pif.enable = 1'b0;
        pif.events = '0;
        pif.halt   = 1'b0;
        pif.clear  = 1'b0;
        pif.rd_req = 1'b0;
        pif.rd_sel = '0;

        // Reset then count
        rst = 1'b0;
        cyc(2);
        check("reset_rd_valid", 32'(pif.rd_valid), 32'd0);
        check("reset_ovf", 32'(pif.ovf), 32'd0);
        check("reset_frozen", 32'(pif.frozen), 32'd0);
        rst = 1'b1;
        pif.enable = 1'b1;
        pif.events = 6'b000011;
        cyc(10);
        pif.enable = 1'b0;
        pif.events = '0;
        rd(0, 10, 1'b0, "t1_sel0");
        rd(1, 10, 1'b0, "t1_sel1");
        rd(3, 0, 1'b0, "t1_sel3");
        rd(2, 10, 1'b0, "t1_sel2");

        // Enable low: events and cycles do not count
        pif.events = '1;
        cyc(5);
        pif.events = '0;
        rd(0, 10, 1'b0, "en_low_sel0");
        rd(1, 10, 1'b0, "en_low_sel1");

        // Halt freeze
        pif.clear = 1'b1;
        cyc(1);
        pif.clear  = 1'b0;
        pif.enable = 1'b1;
        pif.events = 6'b000100;
        cyc(5);
        check("pre_halt_frozen", 32'(pif.frozen), 32'd0);
        pif.halt = 1'b1;
        cyc(1);
        pif.halt = 1'b0;
        check("halt_frozen", 32'(pif.frozen), 32'd1);
        cyc(2);
        pif.halt = 1'b1;
        cyc(1);
        pif.halt = 1'b0;
        cyc(1);
        rd(3, 6, 1'b0, "halt_sel3");
        rd(0, 6, 1'b0, "halt_sel0");
        rd(1, 0, 1'b0, "halt_sel1");
        check("halt_still_frozen", 32'(pif.frozen), 32'd1);
        pif.enable = 1'b0;
        pif.events = '0;

        // Same-cycle clear and read
        pif.clear = 1'b1;
        cyc(1);
        pif.clear = 1'b0;
        check("clear_unfreezes", 32'(pif.frozen), 32'd0);
        pif.enable = 1'b1;
        cyc(7);
        pif.clear = 1'b1;
        rd(0, 7, 1'b0, "clr_rd_sel0");
        pif.clear  = 1'b0;
        pif.enable = 1'b0;
        rd(0, 0, 1'b0, "after_clr_sel0");

        // Bad select
        rd(9, 0, 1'b1, "bad_sel9");
        rd(15, 0, 1'b1, "bad_sel15");
        rd(7, 0, 1'b1, "bad_sel7");
        rd(6, 0, 1'b0, "good_sel6");
        rd(0, 0, 1'b0, "bad_sel_no_change");

        // Halt and clear together: clear wins
        pif.enable = 1'b1;
        pif.halt   = 1'b1;
        pif.clear  = 1'b1;
        cyc(1);
        pif.halt   = 1'b0;
        pif.clear  = 1'b0;
        pif.enable = 1'b0;
        check("halt_clear_frozen", 32'(pif.frozen), 32'd0);

        // Saturation
        pif.enable = 1'b1;
        pif.events = 6'b000001;
        cyc(255);
        check("at_max_no_ovf", 32'(pif.ovf), 32'd0);
        cyc(45);
        pif.enable = 1'b0;
        pif.events = '0;
        check("sat_ovf", 32'(pif.ovf), 32'b0000011);
        rd(1, 255, 1'b0, "sat_sel1");
        rd(0, 255, 1'b0, "sat_sel0");
        rd(2, 0, 1'b0, "sat_sel2");
        pif.clear = 1'b1;
        cyc(1);
        pif.clear = 1'b0;
        check("sat_clear_ovf", 32'(pif.ovf), 32'd0);
        rd(1, 0, 1'b0, "sat_clr_sel1");
        rd(0, 0, 1'b0, "sat_clr_sel0");

        // Reset mid-operation
        pif.enable = 1'b1;
        pif.events = '1;
        cyc(2);
        pif.halt = 1'b1;
        cyc(1);
        pif.halt   = 1'b0;
        pif.enable = 1'b0;
        pif.events = '0;
        check("pre_rst_frozen", 32'(pif.frozen), 32'd1);
        rst        = 1'b0;
        pif.rd_req = 1'b1;
        pif.rd_sel = 4'd2;
        cyc(1);
        rst        = 1'b1;
        pif.rd_req = 1'b0;
        pif.rd_sel = '0;
        check("rst_mid_rd_valid", 32'(pif.rd_valid), 32'd0);
        check("rst_mid_frozen", 32'(pif.frozen), 32'd0);
        check("rst_mid_ovf", 32'(pif.ovf), 32'd0);
        for (int s = 0; s <= NE; s++) begin
            rd(s, 0, 1'b0, "rst_mid_cnt");
        end

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) begin
            cyc(1);
        end
        if (sb_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending reads, expected 0", sb_q.size());
        end
        cyc(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
